easyaxi_rd_arb: RTL

//  N-master to 1-slave AXI read-channel arbiter; successor to the point-to-point EasyAXI mst/slv link.
//  AR: round-robin arbitration into a registered AR slice; master index is prepended to ARID.
//  R: routed back by the ID prefix. Per-master outstanding limit with stall.

---
 rtl/easyaxi_rd_arb_pkg.sv | 35 +++
 rtl/easyaxi_rr_arb.sv | 47 ++++
 rtl/easyaxi_rd_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/easyaxi_rd_arb_pkg.sv
// Shared AXI field widths, encodings and round-robin helpers for the EasyAXI read arbiter.
package easyaxi_rd_arb_pkg;

    localparam int unsigned AXI_ID_W    = 4;
    localparam int unsigned AXI_ADDR_W  = 32;
    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;
    localparam int unsigned AXI_DATA_W  = 64;

    typedef enum logic [AXI_BURST_W-1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } axi_burst_e;

    typedef enum logic [AXI_RESP_W-1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    // Wrap a candidate index that is known to be below 2*n back into [0, n).
    function automatic int unsigned rr_wrap(input int unsigned x, input int unsigned n);
        return (x >= n) ? x - n : x;
    endfunction

    // Pointer value following a grant to index k.
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/easyaxi_rr_arb.sv
// Round-robin arbiter: one-hot grant and index, pointer advances past the winner.
module easyaxi_rr_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int unsigned MST_NUM = 2,
    parameter int unsigned IDX_W   = $clog2(MST_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MST_NUM-1:0] req,
    output logic [MST_NUM-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // First requester at or after the pointer wins; the pointer then moves past it.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned i = 0; i < MST_NUM; i++) begin
            for (int unsigned j = 0; j < MST_NUM; j++) begin
                if (!grant_valid && req[j] && (j == rr_wrap(32'(rr_ptr_q) + i, MST_NUM))) begin
                    grant[j]    = 1'b1;
                    grant_idx   = IDX_W'(j);
                    grant_valid = 1'b1;
                end
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = IDX_W'(rr_next(32'(grant_idx), MST_NUM));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/easyaxi_rd_arb.sv
// N-master to 1-slave AXI read arbiter: round-robin AR into a register slice with the
// master index prepended to ARID, R beats routed back by that prefix.
module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int unsigned MST_NUM  = 2,
    parameter int unsigned IDX_W    = $clog2(MST_NUM),
    parameter int unsigned ID_W     = AXI_ID_W,
    parameter int unsigned ADDR_W   = AXI_ADDR_W,
    parameter int unsigned DATA_W   = AXI_DATA_W,
    parameter int unsigned MAX_OUTS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MST_NUM-1:0]               s_arvalid,
    output logic [MST_NUM-1:0]               s_arready,
    input  logic [MST_NUM*ID_W-1:0]          s_arid,
    input  logic [MST_NUM*ADDR_W-1:0]        s_araddr,
    input  logic [MST_NUM*AXI_LEN_W-1:0]     s_arlen,
    input  logic [MST_NUM*AXI_SIZE_W-1:0]    s_arsize,
    input  logic [MST_NUM*AXI_BURST_W-1:0]   s_arburst,
    output logic [MST_NUM-1:0]               s_rvalid,
    input  logic [MST_NUM-1:0]               s_rready,
    output logic [ID_W-1:0]                  s_rid,
    output logic [DATA_W-1:0]                s_rdata,
    output logic [AXI_RESP_W-1:0]            s_rresp,
    output logic                             s_rlast,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    output logic [IDX_W+ID_W-1:0]            m_arid,
    output logic [ADDR_W-1:0]                m_araddr,
    output logic [AXI_LEN_W-1:0]             m_arlen,
    output logic [AXI_SIZE_W-1:0]            m_arsize,
    output logic [AXI_BURST_W-1:0]           m_arburst,
    input  logic                             m_rvalid,
    input  logic [IDX_W+ID_W-1:0]            m_rid,
    input  logic [DATA_W-1:0]                m_rdata,
    input  logic [AXI_RESP_W-1:0]            m_rresp,
    input  logic                             m_rlast,
    output logic                             m_rready,
    output logic                             err_badid
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);

    logic                   m_arvalid_q;
    logic [IDX_W+ID_W-1:0]  m_arid_q;
    logic [ADDR_W-1:0]      m_araddr_q;
    logic [AXI_LEN_W-1:0]   m_arlen_q;
    logic [AXI_SIZE_W-1:0]  m_arsize_q;
    logic [AXI_BURST_W-1:0] m_arburst_q;
    logic                   err_badid_q;
    logic [CNT_W-1:0]       outs_cnt_q [MST_NUM];

    logic                   slot_free;
    logic [MST_NUM-1:0]     arb_req;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_valid;
    logic [ID_W-1:0]        sel_id;
    logic [ADDR_W-1:0]      sel_addr;
    logic [AXI_LEN_W-1:0]   sel_len;
    logic [AXI_SIZE_W-1:0]  sel_size;
    logic [AXI_BURST_W-1:0] sel_burst;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_bad;
    logic [MST_NUM-1:0]     r_dec;

    easyaxi_rr_arb #(
        .MST_NUM (MST_NUM),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (arb_req),
        .grant       (s_arready),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Eligibility masking and winner payload select; arbitrate only when the slice can accept.
    always_comb begin
        slot_free = !m_arvalid_q || m_arready;
        arb_req   = '0;
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int unsigned k = 0; k < MST_NUM; k++) begin
            arb_req[k] = slot_free && s_arvalid[k] && (outs_cnt_q[k] < CNT_W'(MAX_OUTS));
            if (s_arready[k]) begin
                sel_id    = s_arid[k*ID_W +: ID_W];
                sel_addr  = s_araddr[k*ADDR_W +: ADDR_W];
                sel_len   = s_arlen[k*AXI_LEN_W +: AXI_LEN_W];
                sel_size  = s_arsize[k*AXI_SIZE_W +: AXI_SIZE_W];
                sel_burst = s_arburst[k*AXI_BURST_W +: AXI_BURST_W];
            end
        end
    end

    // AR register slice: load on grant, drain when free and idle, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_arvalid_q <= 1'b0;
            m_arid_q    <= '0;
            m_araddr_q  <= '0;
            m_arlen_q   <= '0;
            m_arsize_q  <= '0;
            m_arburst_q <= '0;
        end else if (slot_free) begin
            m_arvalid_q <= grant_valid;
            if (grant_valid) begin
                m_arid_q    <= {grant_idx, sel_id};
                m_araddr_q  <= sel_addr;
                m_arlen_q   <= sel_len;
                m_arsize_q  <= sel_size;
                m_arburst_q <= sel_burst;
            end
        end
    end

    // R demux by ID prefix; beats with an out-of-range prefix are accepted and dropped.
    always_comb begin
        r_idx    = m_rid[IDX_W+ID_W-1:ID_W];
        r_bad    = 32'(r_idx) >= MST_NUM;
        s_rvalid = '0;
        m_rready = r_bad;
        r_dec    = '0;
        for (int unsigned k = 0; k < MST_NUM; k++) begin
            if (!r_bad && (32'(r_idx) == k)) begin
                s_rvalid[k] = m_rvalid;
                m_rready    = s_rready[k];
                r_dec[k]    = m_rvalid && s_rready[k] && m_rlast;
            end
        end
    end

    // Outstanding-burst counters; simultaneous grant and RLAST cancel, zero never underflows.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < MST_NUM; k++) begin
            if (rst) begin
                outs_cnt_q[k] <= '0;
            end else if (s_arready[k] && !r_dec[k]) begin
                outs_cnt_q[k] <= outs_cnt_q[k] + CNT_W'(1);
            end else if (!s_arready[k] && r_dec[k] && (outs_cnt_q[k] != '0)) begin
                outs_cnt_q[k] <= outs_cnt_q[k] - CNT_W'(1);
            end
        end
    end

    // Sticky flag for R beats carrying an unknown master prefix.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_badid_q <= 1'b0;
        end else if (m_rvalid && r_bad) begin
            err_badid_q <= 1'b1;
        end
    end

    assign m_arvalid = m_arvalid_q;
    assign m_arid    = m_arid_q;
    assign m_araddr  = m_araddr_q;
    assign m_arlen   = m_arlen_q;
    assign m_arsize  = m_arsize_q;
    assign m_arburst = m_arburst_q;
    assign err_badid = err_badid_q;
    assign s_rid     = m_rid[ID_W-1:0];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;

endmodule
